// File: rtl/ram_dp_sync_if.sv
// Port bundle for ram_dp_sync: two independent request/response ports plus shared status.
// The master side issues requests; the slave side is the memory.
interface ram_dp_sync_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  ready;
   logic                  collision;

   logic                  cs_0;
   logic                  we_0;
   logic [ADDR_WIDTH-1:0] address_0;
   logic [DATA_WIDTH-1:0] data_in_0;
   logic [DATA_WIDTH-1:0] data_out_0;
   logic                  valid_0;

   logic                  cs_1;
   logic                  we_1;
   logic [ADDR_WIDTH-1:0] address_1;
   logic [DATA_WIDTH-1:0] data_in_1;
   logic [DATA_WIDTH-1:0] data_out_1;
   logic                  valid_1;

   modport master (
      input  ready, collision,
      output cs_0, we_0, address_0, data_in_0,
      input  data_out_0, valid_0,
      output cs_1, we_1, address_1, data_in_1,
      input  data_out_1, valid_1
   );

   modport slave (
      output ready, collision,
      input  cs_0, we_0, address_0, data_in_0,
      output data_out_0, valid_0,
      input  cs_1, we_1, address_1, data_in_1,
      output data_out_1, valid_1
   );
endinterface

// File: rtl/ram_dp_sync.sv
// Synchronous true dual-port RAM: registered reads (1 or 2 cycles), cross-port collision
// policy and a post-reset clear sequence that zeroes the array before requests are accepted.
module ram_dp_sync #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 8,
   parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
   parameter int READ_LATENCY   = 1,
   parameter int RW_MODE        = 0,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic         clk,
   input  logic         reset_L,
   ram_dp_sync_if.slave bus
);

   typedef enum logic {CLEAR, RUN} state_t;

   localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH+1)'(RAM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   state_t                state;
   logic                  ready_q;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  collision_q;

   logic                  in_rng_0, in_rng_1, same_addr;
   logic                  rd_0, rd_1, wr_0, wr_1, col_next;
   logic [DATA_WIDTH-1:0] rd_data_0, rd_data_1;

   logic                  v1_0, v1_1;
   logic [DATA_WIDTH-1:0] d1_0, d1_1;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      in_rng_0  = {1'b0, bus.address_0} < DEPTH_X;
      in_rng_1  = {1'b0, bus.address_1} < DEPTH_X;
      same_addr = bus.address_0 == bus.address_1;
      rd_0      = ready_q & bus.cs_0 & ~bus.we_0;
      rd_1      = ready_q & bus.cs_1 & ~bus.we_1;
      wr_0      = ready_q & bus.cs_0 & bus.we_0 & in_rng_0;
      wr_1      = ready_q & bus.cs_1 & bus.we_1 & in_rng_1;
      col_next  = ready_q & bus.cs_0 & bus.cs_1 & same_addr & in_rng_0 & (bus.we_0 | bus.we_1);
      rd_data_0 = in_rng_0 ? mem[bus.address_0] : '0;
      rd_data_1 = in_rng_1 ? mem[bus.address_1] : '0;
      // Write-first forwards the other port's write data past the array.
      if (RW_MODE == 1 && wr_1 && same_addr) rd_data_0 = bus.data_in_1;
      if (RW_MODE == 1 && wr_0 && same_addr) rd_data_1 = bus.data_in_0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state   <= CLEAR;
         ready_q <= 1'b0;
         clr_cnt <= '0;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (!CLEAR_ON_RESET || clr_cnt == LAST_ADDR) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the array has no reset term; it is zeroed by the sequenced clear so it maps onto block RAM.
   // reset_L gates the clear so holding reset never touches the contents.
   always_ff @(posedge clk) begin
      if (CLEAR_ON_RESET && reset_L && state == CLEAR) begin
         mem[clr_cnt] <= '0;
      end else begin
         // Port 0 is assigned last so it wins a same-address double write.
         if (wr_1) mem[bus.address_1] <= bus.data_in_1;
         if (wr_0) mem[bus.address_0] <= bus.data_in_0;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         v1_0        <= 1'b0;
         v1_1        <= 1'b0;
         d1_0        <= '0;
         d1_1        <= '0;
         collision_q <= 1'b0;
      end else begin
         v1_0        <= rd_0;
         v1_1        <= rd_1;
         collision_q <= col_next;
         if (rd_0) d1_0 <= rd_data_0;
         if (rd_1) d1_1 <= rd_data_1;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  v2_0, v2_1;
         logic [DATA_WIDTH-1:0] d2_0, d2_1;

         always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
               v2_0 <= 1'b0;
               v2_1 <= 1'b0;
               d2_0 <= '0;
               d2_1 <= '0;
            end else begin
               v2_0 <= v1_0;
               v2_1 <= v1_1;
               if (v1_0) d2_0 <= d1_0;
               if (v1_1) d2_1 <= d1_1;
            end
         end

         assign bus.valid_0    = v2_0;
         assign bus.valid_1    = v2_1;
         assign bus.data_out_0 = d2_0;
         assign bus.data_out_1 = d2_1;
      end else begin : g_lat1
         assign bus.valid_0    = v1_0;
         assign bus.valid_1    = v1_1;
         assign bus.data_out_0 = d1_0;
         assign bus.data_out_1 = d1_1;
      end
   endgenerate

   assign bus.ready     = ready_q;
   assign bus.collision = collision_q;

endmodule

// File: doc/ram_dp_sync.md
Name: ram_dp_sync

Overview:
Synchronous true dual-port RAM. It is the clocked, parametrised successor to the team's asynchronous dual-port RAM. Two independent read/write ports share one clock. Each port has registered reads with a configurable 1- or 2-cycle latency and a read-valid strobe. A defined policy resolves same-address collisions between ports, and a hardware clear sequence zeroes the array after reset. It serves as the buffer memory behind FIFOs and packet stores in the datapath.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 8, address width in bits
RAM_DEPTH, 1<<ADDR_WIDTH, number of words; must be <= 2^ADDR_WIDTH
READ_LATENCY, 1, cycles from read request to data_out/valid; legal values 1 or 2
RW_MODE, 0, cross-port same-address read/write: 0 = read-first (old data), 1 = write-first (new data)
CLEAR_ON_RESET, 1, 1 = zero all words after reset release; 0 = skip the clear

Ports:
clk  input  1  single clock; all state changes on the rising edge
reset_L  input  1  asynchronous, active-low reset
ready  output  1  1 = array accepts requests; 0 during the clear sequence
cs_0  input  1  port 0 chip select
we_0  input  1  port 0 write enable (1 = write, 0 = read)
address_0  input  ADDR_WIDTH  port 0 address
data_in_0  input  DATA_WIDTH  port 0 write data
data_out_0  output  DATA_WIDTH  port 0 read data
valid_0  output  1  port 0 read-data valid strobe
cs_1, we_1, address_1, data_in_1, data_out_1, valid_1: same as port 0, for port 1
collision  output  1  one-cycle pulse flagging a same-address conflict

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is reset_L.
- Reset (reset_L=0, asynchronous):
  - Outputs: ready=0, data_out_0/1=0, valid_0/1=0, collision=0.
  - Read pipelines are flushed and the clear counter is set to 0.
  - Memory contents are not reset by assertion itself.
- Init FSM, states CLEAR and RUN:
  - On reset release the FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - In CLEAR, each edge writes 0 to mem[clr_cnt] and increments clr_cnt.
  - When clr_cnt==RAM_DEPTH-1 is written, the next state is RUN.
  - ready=1 exactly when in RUN, so the clear takes RAM_DEPTH cycles.
- Requests while ready=0 are ignored: no write, no valid.
- Request sampling: a request is sampled at the rising edge when ready=1 and cs_n=1.
  - we_n=1: mem[address_n] <= data_in_n. valid_n is not asserted.
  - we_n=0: data_out_n carries mem[address_n] and valid_n=1 exactly READ_LATENCY edges later, for one cycle.
- Throughput: back-to-back requests are accepted every cycle on both ports, with no stalls.
- Output hold: data_out_n holds its last read value while valid_n=0.
- Out-of-range address (address >= RAM_DEPTH): writes are dropped; reads return 0 with valid asserted normally.
- Both ports write the same address in the same cycle: port 0 data is stored, port 1 is discarded.
- One port reads and the other writes the same address in the same cycle:
  - RW_MODE=0: the reader gets the pre-write value.
  - RW_MODE=1: the reader gets the written data.
- Both ports read the same address: both get the same data; this is not a collision.
- collision:
  - Pulses 1 for one cycle, one edge after any same-cycle, same-address, in-range access pair in which at least one port writes.
  - Registered, independent of READ_LATENCY.
- Reset during operation:
  - In-flight reads are dropped and never produce valid.
  - The clear sequence restarts from address 0.
- READ_LATENCY=2 adds one output register stage. Data and valid move together through it.

Test Plan:
1. ADDR_WIDTH=4, CLEAR_ON_RESET=1: release reset_L -> ready=0 for 16 cycles then 1. Read all 16 addresses -> each returns 0x00 with valid.
2. Port 0 writes 0xA5 to addr 3, next cycle port 1 reads addr 3 -> data_out_1=0xA5, valid_1=1 exactly 1 cycle after the read (READ_LATENCY=1). Repeat with READ_LATENCY=2 -> 2 cycles.
3. Same cycle: port 0 writes 0x11 and port 1 writes 0x22 to addr 7 -> collision=1 next cycle; a later read of addr 7 returns 0x11.
4. addr 5 holds 0x33; port 0 writes 0x44 to addr 5 while port 1 reads addr 5 -> RW_MODE=0 gives 0x33 with collision=1; RW_MODE=1 gives 0x44.
5. Back-to-back reads of addr 0..15 on both ports for 16 cycles -> 16 consecutive valid pulses per port with correct data, no gaps.
6. Assert reset_L=0 one cycle after a read request with READ_LATENCY=2 -> valid never asserts; ready=0 and the clear restarts; after 16 cycles ready=1 and all words read 0.
